// File: rtl/mem_read_initiator.sv
// Valid/ready front end for a synchronous-read memory port with response FIFO.
// Define MEM_READ_INITIATOR_BYPASS_EN for 1-cycle latency when the FIFO is empty.
module mem_read_initiator #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_W-1:0] fifo [RSP_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic              pop;
  logic              issue;
  logic              push;
  logic              fifo_pop;
  logic              bypass;
  logic [CW1-1:0]    credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MEM_READ_INITIATOR_BYPASS_EN
  assign bypass   = inflight && (count == '0);
  assign rsp_data = bypass ? mem_rdata : fifo[rd_ptr];
`else
  assign bypass   = 1'b0;
  assign rsp_data = fifo[rd_ptr];
`endif

  assign mem_raddr = req_addr;
  assign rsp_valid = (count != '0) || bypass;
  assign pop       = rsp_valid && rsp_ready;
  assign fifo_pop  = pop && !bypass;
  assign push      = inflight && !(bypass && pop);

  // Credits cover both stored and in-flight data, net of this cycle's pop.
  assign credit    = CW1'(count) + CW1'(inflight) - CW1'(pop);
  assign req_ready = credit < CW1'(RSP_DEPTH);
  assign issue     = req_valid && req_ready;
  assign busy      = inflight || (count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
    end else begin
      inflight <= issue;
      if (push) begin
        fifo[wr_ptr] <= mem_rdata;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (fifo_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  a_count_max: assert property (
    @(posedge clock) disable iff (!reset) count <= CW'(RSP_DEPTH));

  a_push_full: assert property (
    @(posedge clock) disable iff (!reset)
    !(push && count == CW'(RSP_DEPTH)));

endmodule

// File: tb/tb_mem_read_initiator.sv
// Bench for mem_read_initiator: RSP_DEPTH 2 and 3 instances side by side,
// vector table plus queue-based reference model of request/response ordering.
module tb_mem_read_initiator;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NI = 2;
`ifdef MEM_READ_INITIATOR_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam bit BYP = (LAT == 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [NI-1:0] rr;
  logic [NI-1:0] rv;
  logic [NI-1:0] bz;
  logic [DW-1:0] rd [NI];
  logic [AW-1:0] ra [NI];
  logic [AW-1:0] raddr_q [NI];
  logic [DW-1:0] mdat [NI];
  logic [DW-1:0] mem [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [AW-1:0] a;
    int            t;
  } item_t;

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    bit            rdy;
    bit            err;
    bit            erv;
    logic [DW-1:0] ed;
  } vec_t;

  item_t q0[$];
  item_t q1[$];
  vec_t  vec[$];
  bit    pop_m [NI];
  bit    iss_m [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_read_initiator #(
      .ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(g + 2)
    ) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(rr[g]),
      .req_addr(req_addr),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready),
      .rsp_data(rd[g]),
      .mem_raddr(ra[g]), .mem_rdata(mdat[g]),
      .busy(bz[g])
    );
    always_ff @(posedge clock) raddr_q[g] <= ra[g];
    assign mdat[g] = mem[raddr_q[g]];
  end

  initial forever #5 clock = ~clock;

  function automatic logic [DW-1:0] md(input int i);
    return {32'hDEAD_BEEF, 32'(i)};
  endfunction

  function automatic int qn(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic item_t qh(input int g);
    return (g == 0) ? q0[0] : q1[0];
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Oldest outstanding request becomes visible LAT cycles after acceptance.
  task automatic model_check();
    for (int g = 0; g < NI; g++) begin
      int    n;
      int    dep;
      bit    erv;
      bit    err;
      item_t h;
      dep = g + 2;
      n   = qn(g);
      erv = 1'b0;
      h.a = '0;
      h.t = 0;
      if (n > 0) begin
        h   = qh(g);
        erv = (cyc - h.t) >= LAT;
      end
      if (!reset) erv = 1'b0;
      pop_m[g] = erv && rsp_ready;
      err = !reset || ((n - int'(pop_m[g])) < dep);
      iss_m[g] = reset && req_valid && err;
      chk($sformatf("req_ready%0d", g), DW'(rr[g]), DW'(err));
      chk($sformatf("rsp_valid%0d", g), DW'(rv[g]), DW'(erv));
      chk($sformatf("busy%0d", g), DW'(bz[g]), DW'(n != 0));
      chk($sformatf("mem_raddr%0d", g), DW'(ra[g]), DW'(req_addr));
      if (erv) chk($sformatf("rsp_data%0d", g), rd[g], mem[h.a]);
    end
  endtask

  task automatic model_update();
    item_t it;
    it.a = req_addr;
    it.t = cyc;
    if (!reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop_m[0]) void'(q0.pop_front());
      if (iss_m[0]) q0.push_back(it);
      if (pop_m[1]) void'(q1.pop_front());
      if (iss_m[1]) q1.push_back(it);
    end
    cyc++;
  endtask

  task automatic half_a();
    @(negedge clock);
    model_check();
  endtask

  task automatic half_b();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic add(input bit v, input int a, input bit rdy,
                     input bit err, input bit erv, input logic [DW-1:0] ed);
    vec_t e;
    e.v = v; e.a = AW'(a); e.rdy = rdy;
    e.err = err; e.erv = erv; e.ed = ed;
    vec.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = md(i);

    // single request to addr 3
    add(1, 3, 1, 1, 0, '0);
    add(0, 0, 1, 1, BYP, md(3));
    add(0, 0, 1, 1, !BYP, md(3));
    add(0, 0, 1, 1, 0, '0);
    // backpressure: only 7 and 8 fit while stalled
    add(1, 7, 0, 1, 0, '0);
    add(1, 8, 0, 1, BYP, md(7));
    add(1, 9, 0, 0, 1, md(7));
    add(1, 9, 0, 0, 1, md(7));
    add(1, 9, 0, 0, 1, md(7));
    add(1, 9, 1, 1, 1, md(7));
    add(1, 10, 1, 1, 1, md(8));
    add(1, 11, 1, 1, 1, md(9));
    add(0, 0, 1, 1, 1, md(10));
    add(0, 0, 1, 1, 1, md(11));
    add(0, 0, 1, 1, 0, '0);

    #2 reset = 1'b0;
    tick();
    half_a();
    chk("rst_data0", rd[0], '0);
    chk("rst_data1", rd[1], '0);
    half_b();
    reset = 1'b1;
    tick();

    foreach (vec[k]) begin
      req_valid = vec[k].v;
      req_addr  = vec[k].a;
      rsp_ready = vec[k].rdy;
      half_a();
      chk("tbl_rr", DW'(rr[0]), DW'(vec[k].err));
      chk("tbl_rv", DW'(rv[0]), DW'(vec[k].erv));
      if (vec[k].erv) chk("tbl_rd", rd[0], vec[k].ed);
      half_b();
    end

    rsp_ready = 1'b1;
    for (int k = 0; k < 34; k++) begin
      req_valid = (k < 32);
      req_addr  = AW'(k);
      half_a();
      if (k < 32) chk("thr_rr", DW'(rr[0]), 1);
      if (k >= LAT && k - LAT < 32) begin
        chk("thr_rv", DW'(rv[0]), 1);
        chk("thr_rd", rd[0], md(k - LAT));
      end
      half_b();
    end

    // reset with two entries queued
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 5'd12;
    tick();
    req_addr  = 5'd13;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rv0", DW'(rv[0]), 0);
    chk("mid_rst_rv1", DW'(rv[1]), 0);
    chk("mid_rst_bz0", DW'(bz[0]), 0);
    q0.delete();
    q1.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_bz0", DW'(bz[0]), 0);
    chk("post_rst_rv0", DW'(rv[0]), 0);

    // alternating stall blocks to walk pointers around
    req_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      req_addr  = AW'(k * 7);
      rsp_ready = ((k / 3) % 2) == 1;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    for (int k = 0; k < 10000; k++) begin
      req_valid = 1'($urandom % 2);
      rsp_ready = 1'($urandom % 2);
      req_addr  = AW'($urandom);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("final_bz0", DW'(bz[0]), 0);
    chk("final_bz1", DW'(bz[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
